// File: rtl/fetch_queue.sv
// Circular FIFO decoupling instruction fetch from decode: holds instruction, PC
// and branch-predictor result per entry, first-word fall-through on the head.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid_i,
  output logic                   enq_ready_o,
  input  logic [INSTR_WIDTH-1:0] enq_instr_i,
  input  logic [ADDR_WIDTH-1:0]  enq_pc_i,
  input  logic                   enq_pred_hit_i,
  input  logic                   enq_pred_taken_i,
  input  logic                   flush_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output logic [INSTR_WIDTH-1:0] deq_instr_o,
  output logic [ADDR_WIDTH-1:0]  deq_pc_o,
  output logic                   deq_pred_hit_o,
  output logic                   deq_pred_taken_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
  logic                   hit_mem   [DEPTH];
  logic                   taken_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire;

  // Ready/valid come only from the registered count, so no input reaches an output.
  assign enq_ready_o = (count_q != CNT_W'(DEPTH));
  assign deq_valid_o = (count_q != '0);
  assign count_o     = count_q;

  // Flush cancels both handshakes in its cycle.
  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire = deq_valid_o && deq_ready_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CNT_W'(1);
      else if (deq_fire && !enq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; its contents are irrelevant while count is zero.
  always_ff @(posedge clk) begin
    if (enq_fire && !rst) begin
      instr_mem[wr_ptr_q] <= enq_instr_i;
      pc_mem[wr_ptr_q]    <= enq_pc_i;
      hit_mem[wr_ptr_q]   <= enq_pred_hit_i;
      taken_mem[wr_ptr_q] <= enq_pred_taken_i;
    end
  end

  always_comb begin
    deq_instr_o      = NOP;
    deq_pc_o         = '0;
    deq_pred_hit_o   = 1'b0;
    deq_pred_taken_o = 1'b0;
    if (deq_valid_o) begin
      deq_instr_o      = instr_mem[rd_ptr_q];
      deq_pc_o         = pc_mem[rd_ptr_q];
      deq_pred_hit_o   = hit_mem[rd_ptr_q];
      deq_pred_taken_o = hit_mem[rd_ptr_q] && taken_mem[rd_ptr_q];
    end
  end

endmodule
